// File: rtl/ipmxb_qsgmii_hsst_lane_rst_ctrl.sv
// QSGMII HSST lane reset sequencer: PLL reset, PLL lock, PMA reset, CDR lock, PCS reset, done.
// Lock inputs are double-flop synchronized; timeouts and lock losses restart the sequence.
//
// state    | meaning
// PLL_RST  | hold PLL, PMA and PCS in reset for PLL_RST_CYC cycles
// PLL_WAIT | wait for PLL lock, retry PLL reset on timeout
// PMA_RST  | hold PMA reset for PMA_RST_CYC cycles with PLL locked
// CDR_WAIT | wait for CDR_STABLE_CYC consecutive CDR lock cycles, retry PMA on timeout
// PCS_RST  | hold PCS reset for PCS_RST_CYC cycles
// DONE     | lane up, monitor both locks
module ipmxb_qsgmii_hsst_lane_rst_ctrl #(
    parameter int unsigned PLL_RST_CYC    = 16,
    parameter int unsigned PLL_LOCK_TO    = 50000,
    parameter int unsigned PMA_RST_CYC    = 16,
    parameter int unsigned CDR_STABLE_CYC = 1024,
    parameter int unsigned CDR_LOCK_TO    = 60000,
    parameter int unsigned PCS_RST_CYC    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soft_rst,
    input  logic       pll_lock_async,
    input  logic       cdr_lock_async,
    output logic       pll_rst,
    output logic       pma_rst,
    output logic       pcs_rst,
    output logic       rst_done,
    output logic [2:0] state_o,
    output logic [7:0] fail_cnt
);

    typedef enum logic [2:0] {
        PLL_RST  = 3'd0,
        PLL_WAIT = 3'd1,
        PMA_RST  = 3'd2,
        CDR_WAIT = 3'd3,
        PCS_RST  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [15:0] PLL_RST_LAST = 16'(PLL_RST_CYC - 1);
    localparam logic [15:0] PLL_TO_LAST  = 16'(PLL_LOCK_TO - 1);
    localparam logic [15:0] PMA_RST_LAST = 16'(PMA_RST_CYC - 1);
    localparam logic [15:0] CDR_STB_LAST = 16'(CDR_STABLE_CYC - 1);
    localparam logic [15:0] CDR_TO_LAST  = 16'(CDR_LOCK_TO - 1);
    localparam logic [15:0] PCS_RST_LAST = 16'(PCS_RST_CYC - 1);

    state_t      state;
    state_t      nxt;
    logic [15:0] timer;
    logic [15:0] stable_cnt;
    logic        pll_sync1;
    logic        pll_lock_s;
    logic        cdr_sync1;
    logic        cdr_lock_s;
    logic        fail_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_sync1  <= 1'b0;
            pll_lock_s <= 1'b0;
            cdr_sync1  <= 1'b0;
            cdr_lock_s <= 1'b0;
        end else begin
            pll_sync1  <= pll_lock_async;
            pll_lock_s <= pll_sync1;
            cdr_sync1  <= cdr_lock_async;
            cdr_lock_s <= cdr_sync1;
        end
    end

    // Lock checks precede timer checks so a lock arriving on the timeout cycle wins.
    always_comb begin
        nxt      = state;
        fail_inc = 1'b0;
        if (soft_rst) begin
            nxt = PLL_RST;
        end else begin
            case (state)
                PLL_RST: begin
                    if (timer == PLL_RST_LAST) nxt = PLL_WAIT;
                end
                PLL_WAIT: begin
                    if (pll_lock_s) begin
                        nxt = PMA_RST;
                    end else if (timer == PLL_TO_LAST) begin
                        nxt      = PLL_RST;
                        fail_inc = 1'b1;
                    end
                end
                PMA_RST: begin
                    if (!pll_lock_s)                nxt = PLL_RST;
                    else if (timer == PMA_RST_LAST) nxt = CDR_WAIT;
                end
                CDR_WAIT: begin
                    if (!pll_lock_s) begin
                        nxt      = PLL_RST;
                        fail_inc = 1'b1;
                    end else if (cdr_lock_s && stable_cnt == CDR_STB_LAST) begin
                        nxt = PCS_RST;
                    end else if (timer == CDR_TO_LAST) begin
                        nxt      = PMA_RST;
                        fail_inc = 1'b1;
                    end
                end
                PCS_RST: begin
                    if (!pll_lock_s)                nxt = PLL_RST;
                    else if (!cdr_lock_s)           nxt = PMA_RST;
                    else if (timer == PCS_RST_LAST) nxt = DONE;
                end
                DONE: begin
                    if (!pll_lock_s) begin
                        nxt      = PLL_RST;
                        fail_inc = 1'b1;
                    end else if (!cdr_lock_s) begin
                        nxt      = PMA_RST;
                        fail_inc = 1'b1;
                    end
                end
                default: nxt = PLL_RST;
            endcase
        end
    end

    // Outputs are registered from the next state so they move together with state_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PLL_RST;
            timer      <= 16'd0;
            stable_cnt <= 16'd0;
            fail_cnt   <= 8'd0;
            pll_rst    <= 1'b1;
            pma_rst    <= 1'b1;
            pcs_rst    <= 1'b1;
            rst_done   <= 1'b0;
        end else begin
            state <= nxt;
            if (soft_rst || nxt != state)
                timer <= 16'd0;
            else if (timer != 16'hFFFF)
                timer <= timer + 16'd1;
            if (nxt != state || state != CDR_WAIT || !cdr_lock_s)
                stable_cnt <= 16'd0;
            else
                stable_cnt <= stable_cnt + 16'd1;
            if (fail_inc && fail_cnt != 8'hFF)
                fail_cnt <= fail_cnt + 8'd1;
            pll_rst  <= (nxt == PLL_RST);
            pma_rst  <= (nxt == PLL_RST) || (nxt == PLL_WAIT) || (nxt == PMA_RST);
            pcs_rst  <= (nxt != DONE);
            rst_done <= (nxt == DONE);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ipmxb_qsgmii_hsst_lane_rst_ctrl.sv
// Directed bench for the lane reset sequencer with short bench timing parameters.
module tb_ipmxb_qsgmii_hsst_lane_rst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       soft_rst;
    logic       pll_lock_async;
    logic       cdr_lock_async;
    logic       pll_rst;
    logic       pma_rst;
    logic       pcs_rst;
    logic       rst_done;
    logic [2:0] state_o;
    logic [7:0] fail_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ipmxb_qsgmii_hsst_lane_rst_ctrl #(
        .PLL_RST_CYC    (4),
        .PLL_LOCK_TO    (20),
        .PMA_RST_CYC    (3),
        .CDR_STABLE_CYC (5),
        .CDR_LOCK_TO    (30),
        .PCS_RST_CYC    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .soft_rst       (soft_rst),
        .pll_lock_async (pll_lock_async),
        .cdr_lock_async (cdr_lock_async),
        .pll_rst        (pll_rst),
        .pma_rst        (pma_rst),
        .pcs_rst        (pcs_rst),
        .rst_done       (rst_done),
        .state_o        (state_o),
        .fail_cnt       (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic pr,
                            input logic mr, input logic cr, input logic dn, input logic [7:0] fc);
        chk({tag, "_state"}, 16'(state_o), 16'(st));
        chk({tag, "_pll_rst"}, 16'(pll_rst), 16'(pr));
        chk({tag, "_pma_rst"}, 16'(pma_rst), 16'(mr));
        chk({tag, "_pcs_rst"}, 16'(pcs_rst), 16'(cr));
        chk({tag, "_rst_done"}, 16'(rst_done), 16'(dn));
        chk({tag, "_fail_cnt"}, 16'(fail_cnt), 16'(fc));
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; soft_rst = 1'b0; pll_lock_async = 1'b1; cdr_lock_async = 1'b1;

        // Nominal bring-up
        tick(2);
        chk_outs("reset", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick(3);  chk_outs("nom_e3", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);  chk_outs("nom_e4", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);  chk_outs("nom_e5", 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(2);  chk_outs("nom_e7", 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);  chk_outs("nom_e8", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(5);  chk_outs("nom_e13", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);  chk_outs("nom_e14", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);  chk_outs("nom_e15", 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // One-cycle CDR drop in DONE
        cdr_lock_async = 1'b0;
        tick(1);  cdr_lock_async = 1'b1;
        tick(1);  chk_outs("cdrloss_e2", 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        tick(1);  chk_outs("cdrloss_e3", 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
        tick(9);  chk("cdrloss_e12_state", 16'(state_o), 16'd4);
        tick(1);  chk_outs("cdrloss_relock", 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

        // soft_rst pulse in DONE
        soft_rst = 1'b1;
        tick(1);  soft_rst = 1'b0;
        chk_outs("soft_rst", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        tick(4);  chk("soft_s4_state", 16'(state_o), 16'd1);
        tick(11); chk_outs("soft_redone", 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

        // Simultaneous PLL and CDR loss, then PLL stays unlocked
        pll_lock_async = 1'b0; cdr_lock_async = 1'b0;
        tick(2);  chk("both_t2_state", 16'(state_o), 16'd5);
        tick(1);  chk_outs("both_t3", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2);
        tick(23); chk_outs("pllto_t26", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
        tick(1);  chk_outs("pllto_t27", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
        tick(24); chk("pllto_t51_fail", 16'(fail_cnt), 16'd4);

        // Asynchronous reset while in CDR_WAIT
        pll_lock_async = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (state_o == 3'd3) found = 1'b1;
        end
        chk("reach_cdr_wait", 16'(found), 16'd1);
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

        // CDR timeout, then glitched CDR lock in the retry
        tick(2);
        rst_n = 1'b1;
        tick(8);  chk("cdrto_e8_state", 16'(state_o), 16'd3);
        tick(29); chk_outs("cdrto_e37", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);  chk_outs("cdrto_e38", 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
        tick(3);  chk("glitch_entry_state", 16'(state_o), 16'd3);
        cdr_lock_async = 1'b1;
        tick(4);  cdr_lock_async = 1'b0;
        tick(1);  cdr_lock_async = 1'b1;
        tick(2);  chk("glitch_e7_state", 16'(state_o), 16'd3);
        tick(4);  chk("glitch_e11_state", 16'(state_o), 16'd3);
        tick(1);  chk_outs("glitch_e12", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        tick(2);  chk_outs("glitch_done", 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

        // PLL never locks from a fresh reset
        rst_n = 1'b0; pll_lock_async = 1'b0; cdr_lock_async = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(23); chk_outs("nolock_e23", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);  chk_outs("nolock_e24", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        tick(24); chk("nolock_e48_fail", 16'(fail_cnt), 16'd2);
        tick(24); chk("nolock_e72_fail", 16'(fail_cnt), 16'd3);
        chk("nolock_e72_state", 16'(state_o), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
